cam_param: RTL and testbench
============================

# cam_param

Parametrised content-addressable memory: the next generation of the team's fixed 32×32 CAM, generalised in depth and data width. Adds per-entry valid bits, an explicit invalidate port, masked (don't-care) search, multi-hit detection and an occupancy counter. Sits beside the lookup datapath. Driven by the clocking-block bench through the CAM interface, extended with the new signals.

## Interface
- DEPTH, 32, number of entries; must be ≥2.
- DATA_WIDTH, 32, entry width in bits.
- INDEX_WIDTH, $clog2(DEPTH), index width.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width.

- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- read_enable_i  in  1  read request.
- read_index_i  in  INDEX_WIDTH  read entry.
- write_enable_i  in  1  write request.
- write_index_i  in  INDEX_WIDTH  write entry.
- write_data_i  in  DATA_WIDTH  write data.
- invalidate_enable_i  in  1  clear the valid bit of one entry.
- invalidate_index_i  in  INDEX_WIDTH  entry to invalidate.
- search_enable_i  in  1  search request.
- search_data_i  in  DATA_WIDTH  search key.
- search_mask_i  in  DATA_WIDTH  per-bit compare enable (1 = compare, 0 = don't care).
- read_valid_o  out  1  read result valid (entry was valid).
- read_value_o  out  DATA_WIDTH  read data.
- search_valid_o  out  1  search hit.
- search_index_o  out  INDEX_WIDTH  lowest matching index.
- search_multi_o  out  1  more than one entry matched.
- occupancy_o  out  CNT_WIDTH  number of valid entries.
- full_o  out  1  occupancy_o == DEPTH.

## Operation
- State:
  - DEPTH×DATA_WIDTH storage; data is not reset.
  - DEPTH valid bits.
  - Occupancy register.
  - Registered read and search outputs.
- Write:
  - Stores write_data_i at write_index_i and sets its valid bit.
  - Writing an already-valid entry overwrites it; occupancy unchanged.
- Invalidate:
  - Clears the valid bit at invalidate_index_i.
  - Invalidating an already-invalid entry is a no-op.
- Write and invalidate in the same cycle, same index: write wins; entry valid with new data.
- Occupancy is updated every cycle from the valid-bit changes:
  - +1 when a write sets a previously clear bit.
  - −1 when an invalidate clears a previously set bit.
  - Both events on different indices net to 0.
  - Never wraps; it is derived from valid-bit changes only.
- Read:
  - Entry valid: read_valid_o = 1 and read_value_o = data.
  - Entry invalid: read_valid_o = 0 and read_value_o = 0.
- Search:
  - Entry i matches iff valid[i] && ((entry[i] ^ search_data_i) & search_mask_i) == 0.
  - search_valid_o = any match.
  - search_index_o = lowest matching index; 0 if no match.
  - search_multi_o = two or more matches.
  - All-zero mask matches every valid entry.
- Read, write, invalidate and search are independent and may all occur in one cycle.
- Out-of-range indices (DEPTH not a power of two, index ≥ DEPTH):
  - Writes and invalidates are ignored.
  - Reads return read_valid_o = 0.

## Timing
- Reset (async assert, sync deassert handled upstream) forces:
  - All valid bits to 0.
  - occupancy_o = 0 and full_o = 0.
  - read_valid_o, read_value_o, search_valid_o, search_index_o and search_multi_o to 0.
- Reset mid-operation discards in-flight read and search results; no output pulses after reset.
- Read latency 1 cycle:
  - Request at edge N; result at edge N+1.
  - Outputs return to 0 in the cycle after a cycle with read_enable_i low.
- Search latency 1 cycle, same rule as read; outputs are zero when no search was issued.
- Read-during-write and search-during-write to the same entry see the old contents and old valid bit. The new value is visible to requests issued in the next cycle.
- Same rule for invalidate: a search in the invalidate cycle can still hit that entry.
- occupancy_o and full_o are registered; they reflect changes one cycle after the write or invalidate edge.
- No back-pressure: one operation of each kind accepted every cycle.

## Test plan
- **Reset and invalid read.** Reset; read index 5.
  - read_valid_o = 0, read_value_o = 0, occupancy_o = 0, full_o = 0.
- **Write then search.** Write 0xDEAD_BEEF to index 3; search 0xDEAD_BEEF with mask all-ones in the following cycle.
  - One cycle later: search_valid_o = 1, search_index_o = 3, search_multi_o = 0, occupancy_o = 1.
- **Multi-hit with mask.** Write 0x1234_0001 at 7 and 0x1234_0002 at 2; search 0x1234_0000 with mask 0xFFFF_0000.
  - search_index_o = 2, search_multi_o = 1.
- **Same-cycle write and search.** Write 0xAAAA_AAAA to index 9 while searching for it.
  - Miss that cycle: search_valid_o = 0.
  - Hit at index 9 on a repeat search the next cycle.
- **Fill and overwrite.** Write all DEPTH entries.
  - full_o = 1 and occupancy_o = 32.
  - Rewrite index 0: occupancy stays 32.
  - Invalidate 0: occupancy 31, full_o = 0, read index 0 gives read_valid_o = 0.
- **Write/invalidate collision and mid-operation reset.** Write and invalidate index 4 together.
  - Entry 4 valid; occupancy +1.
  - Assert rst_i between a search request and its result: search_valid_o stays 0 and occupancy_o = 0.

Source files
------------

// File: rtl/cam_param.sv
// cam_param: parametrised content-addressable memory.
//
// DEPTH entries of DATA_WIDTH bits, each with a valid bit. Supports indexed write, indexed
// invalidate, indexed read and masked associative search, all independent and all accepted
// every cycle. Read and search results are registered (one-cycle latency) and observe the
// array contents as they were before the edge that accepts them. Storage data is never
// reset; only valid bits, occupancy and result registers are.
//
// Ports:
//   clk_i                single clock, rising edge
//   rst_i                asynchronous active-high reset
//   read_enable_i        read request
//   read_index_i         entry to read
//   write_enable_i       write request
//   write_index_i        entry to write
//   write_data_i         data to store
//   invalidate_enable_i  invalidate request
//   invalidate_index_i   entry whose valid bit is cleared
//   search_enable_i      search request
//   search_data_i        search key
//   search_mask_i        per-bit compare enable (1 = compare, 0 = don't care)
//   read_valid_o         read hit a valid entry
//   read_value_o         read data (0 when not valid)
//   search_valid_o       at least one entry matched
//   search_index_o       lowest matching index (0 on miss)
//   search_multi_o       two or more entries matched
//   occupancy_o          number of valid entries
//   full_o               occupancy_o == DEPTH
module cam_param #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   read_enable_i,
  input  logic [INDEX_WIDTH-1:0] read_index_i,
  input  logic                   write_enable_i,
  input  logic [INDEX_WIDTH-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0]  write_data_i,
  input  logic                   invalidate_enable_i,
  input  logic [INDEX_WIDTH-1:0] invalidate_index_i,
  input  logic                   search_enable_i,
  input  logic [DATA_WIDTH-1:0]  search_data_i,
  input  logic [DATA_WIDTH-1:0]  search_mask_i,
  output logic                   read_valid_o,
  output logic [DATA_WIDTH-1:0]  read_value_o,
  output logic                   search_valid_o,
  output logic [INDEX_WIDTH-1:0] search_index_o,
  output logic                   search_multi_o,
  output logic [CNT_WIDTH-1:0]   occupancy_o,
  output logic                   full_o
);

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   occupancy_q, occupancy_d;
  logic                   full_q, full_d;

  logic                   read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0]  read_value_q, read_value_d;
  logic                   search_valid_q, search_valid_d;
  logic [INDEX_WIDTH-1:0] search_index_q, search_index_d;
  logic                   search_multi_q, search_multi_d;

  // ---------------------------------------------------------------------------------------
  // Index decode. Indices >= DEPTH decode to no entry, so out-of-range writes and
  // invalidates are dropped and out-of-range reads miss without any explicit range check.
  // ---------------------------------------------------------------------------------------
  logic [DEPTH-1:0] wr_sel, inv_sel, rd_sel;

  always_comb begin
    wr_sel  = '0;
    inv_sel = '0;
    rd_sel  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_sel[i]  = write_enable_i      && (write_index_i      == INDEX_WIDTH'(i));
      inv_sel[i] = invalidate_enable_i && (invalidate_index_i == INDEX_WIDTH'(i));
      rd_sel[i]  = read_index_i == INDEX_WIDTH'(i);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Valid bits and occupancy. Write wins over invalidate on the same entry.
  // Occupancy moves only on actual valid-bit transitions, so it can never wrap.
  // ---------------------------------------------------------------------------------------
  logic set_event, clr_event;

  always_comb begin
    valid_d     = (valid_q & ~inv_sel) | wr_sel;
    set_event   = |(wr_sel & ~valid_q);
    clr_event   = |(inv_sel & ~wr_sel & valid_q);
    occupancy_d = occupancy_q + CNT_WIDTH'(set_event) - CNT_WIDTH'(clr_event);
    full_d      = occupancy_d == CNT_WIDTH'(DEPTH);
  end

  // ---------------------------------------------------------------------------------------
  // Read path (pre-edge contents)
  // ---------------------------------------------------------------------------------------
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_sel[i] && valid_q[i]) begin
        rd_hit  = 1'b1;
        rd_data = mem_q[i];
      end
    end
    read_valid_d = read_enable_i && rd_hit;
    read_value_d = read_valid_d ? rd_data : '0;
  end

  // ---------------------------------------------------------------------------------------
  // Search path (pre-edge contents)
  // ---------------------------------------------------------------------------------------
  logic [DEPTH-1:0]       match;
  logic [INDEX_WIDTH-1:0] lowest_idx;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (((mem_q[i] ^ search_data_i) & search_mask_i) == '0);
    end
  end

  // Scan downwards so the last assignment is the lowest matching index.
  always_comb begin
    lowest_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match[i]) begin
        lowest_idx = INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    search_valid_d = search_enable_i && (|match);
    search_index_d = search_valid_d ? lowest_idx : '0;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    search_multi_d = search_enable_i && ((match & (match - DEPTH'(1))) != '0);
  end

  // ---------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= write_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q        <= '0;
      occupancy_q    <= '0;
      full_q         <= 1'b0;
      read_valid_q   <= 1'b0;
      read_value_q   <= '0;
      search_valid_q <= 1'b0;
      search_index_q <= '0;
      search_multi_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      occupancy_q    <= occupancy_d;
      full_q         <= full_d;
      read_valid_q   <= read_valid_d;
      read_value_q   <= read_value_d;
      search_valid_q <= search_valid_d;
      search_index_q <= search_index_d;
      search_multi_q <= search_multi_d;
    end
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_valid_o = search_valid_q;
  assign search_index_o = search_index_q;
  assign search_multi_o = search_multi_q;
  assign occupancy_o    = occupancy_q;
  assign full_o         = full_q;

endmodule

// File: tb/tb_cam_param.sv
// Self-checking bench for cam_param: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the entry array kept in the bench.
module tb_cam_param;

  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int IW    = 5;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_enable;
  logic [IW-1:0] read_index;
  logic          write_enable;
  logic [IW-1:0] write_index;
  logic [DW-1:0] write_data;
  logic          invalidate_enable;
  logic [IW-1:0] invalidate_index;
  logic          search_enable;
  logic [DW-1:0] search_data;
  logic [DW-1:0] search_mask;
  logic          read_valid;
  logic [DW-1:0] read_value;
  logic          search_valid;
  logic [IW-1:0] search_index;
  logic          search_multi;
  logic [CW-1:0] occupancy;
  logic          full;

  always #5 clk = ~clk;

  cam_param #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .read_enable_i      (read_enable),
    .read_index_i       (read_index),
    .write_enable_i     (write_enable),
    .write_index_i      (write_index),
    .write_data_i       (write_data),
    .invalidate_enable_i(invalidate_enable),
    .invalidate_index_i (invalidate_index),
    .search_enable_i    (search_enable),
    .search_data_i      (search_data),
    .search_mask_i      (search_mask),
    .read_valid_o       (read_valid),
    .read_value_o       (read_value),
    .search_valid_o     (search_valid),
    .search_index_o     (search_index),
    .search_multi_o     (search_multi),
    .occupancy_o        (occupancy),
    .full_o             (full)
  );

  // Behavioural model: contents plus valid flag per entry.
  logic [DW-1:0] m_data [DEPTH];
  bit            m_valid [DEPTH];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic idle_inputs();
    read_enable       = 1'b0;
    read_index        = '0;
    write_enable      = 1'b0;
    write_index       = '0;
    write_data        = '0;
    invalidate_enable = 1'b0;
    invalidate_index  = '0;
    search_enable     = 1'b0;
    search_data       = '0;
    search_mask       = '0;
  endtask

  // One clock cycle of stimulus; all outputs checked #1 after the accepting edge.
  task automatic step(input bit re, input int ri, input bit we, input int wi,
                      input logic [DW-1:0] wd, input bit ie, input int ii,
                      input bit se, input logic [DW-1:0] sd, input logic [DW-1:0] sm);
    logic          exp_rv, exp_sv, exp_sm;
    logic [DW-1:0] exp_rd;
    int            exp_si, hits, occ;
    @(negedge clk);
    read_enable       = re;
    read_index        = IW'(ri);
    write_enable      = we;
    write_index       = IW'(wi);
    write_data        = wd;
    invalidate_enable = ie;
    invalidate_index  = IW'(ii);
    search_enable     = se;
    search_data       = sd;
    search_mask       = sm;
    // Expected results come from the contents before this edge.
    exp_rv = 1'b0;
    exp_rd = '0;
    if (re && ri < DEPTH && m_valid[ri]) begin
      exp_rv = 1'b1;
      exp_rd = m_data[ri];
    end
    hits   = 0;
    exp_si = 0;
    if (se) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && ((m_data[i] ^ sd) & sm) == '0) begin
          if (hits == 0) exp_si = i;
          hits++;
        end
      end
    end
    exp_sv = hits > 0;
    exp_sm = hits > 1;
    @(posedge clk);
    #1;
    if (ie && ii < DEPTH) m_valid[ii] = 1'b0;
    if (we && wi < DEPTH) begin
      m_data[wi]  = wd;
      m_valid[wi] = 1'b1;
    end
    occ = model_count();
    check("read_valid", 32'(read_valid), 32'(exp_rv));
    check("read_value", read_value, exp_rd);
    check("search_valid", 32'(search_valid), 32'(exp_sv));
    check("search_index", 32'(search_index), 32'(exp_si));
    check("search_multi", 32'(search_multi), 32'(exp_sm));
    check("occupancy", 32'(occupancy), 32'(occ));
    check("full", 32'(full), 32'(occ == DEPTH));
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] key, mask, data;
    int            j;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    idle_inputs();
    rst = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_read_value", read_value, 32'd0);
    check("rst_search_valid", 32'(search_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Invalid read.
    step(1, 5, 0, 0, '0, 0, 0, 0, '0, '0);

    // Write then search.
    step(0, 0, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, 0, 0, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check("dir_hit_index3", 32'(search_index), 32'd3);
    check("dir_occ1", 32'(occupancy), 32'd1);
    idle_step();

    // Multi-hit with mask.
    step(0, 0, 1, 7, 32'h1234_0001, 0, 0, 0, '0, '0);
    step(0, 0, 1, 2, 32'h1234_0002, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, 0, 0, 1, 32'h1234_0000, 32'hFFFF_0000);
    check("dir_multi_index", 32'(search_index), 32'd2);
    check("dir_multi_flag", 32'(search_multi), 32'd1);

    // Same-cycle write and search misses; repeat hits.
    step(0, 0, 1, 9, 32'hAAAA_AAAA, 0, 0, 1, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    check("dir_same_cycle_miss", 32'(search_valid), 32'd0);
    step(0, 0, 0, 0, '0, 0, 0, 1, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    check("dir_repeat_hit", 32'(search_index), 32'd9);

    // All-zero mask matches every valid entry.
    step(0, 0, 0, 0, '0, 0, 0, 1, $urandom, '0);

    // Fill and overwrite.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, i, $urandom, 0, 0, 0, '0, '0);
    check("dir_full", 32'(full), 32'd1);
    check("dir_occ32", 32'(occupancy), 32'd32);
    step(0, 0, 1, 0, 32'h0000_5555, 0, 0, 0, '0, '0);
    check("dir_rewrite_occ", 32'(occupancy), 32'd32);
    step(1, 0, 0, 0, '0, 1, 0, 0, '0, '0);   // read in invalidate cycle still sees entry
    check("dir_inval_occ31", 32'(occupancy), 32'd31);
    step(1, 0, 0, 0, '0, 0, 0, 0, '0, '0);
    check("dir_read_invalid", 32'(read_valid), 32'd0);

    // Write/invalidate collision on an invalid entry.
    step(0, 0, 0, 0, '0, 1, 4, 0, '0, '0);
    step(0, 0, 1, 4, 32'h4444_4444, 1, 4, 0, '0, '0);
    check("dir_collision_occ", 32'(occupancy), 32'd31);
    step(1, 4, 0, 0, '0, 0, 0, 1, 32'h4444_4444, 32'hFFFF_FFFF);
    check("dir_collision_valid", 32'(read_valid), 32'd1);

    // Search in the invalidate cycle still hits.
    step(0, 0, 0, 0, '0, 1, 4, 1, 32'h4444_4444, 32'hFFFF_FFFF);
    check("dir_inval_cycle_hit", 32'(search_valid), 32'd1);

    // Randomized traffic with a small data alphabet so searches hit and multi-hit.
    for (int n = 0; n < 600; n++) begin
      data = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      j    = $urandom_range(0, DEPTH - 1);
      key  = m_valid[j] ? m_data[j] : DW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       mask = '1;
        1:       mask = '0;
        2:       mask = 32'h0000_0003;
        default: mask = $urandom;
      endcase
      key = key ^ ($urandom & ~mask);
      step($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1), data,
           $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 3) != 0, key, mask);
    end

    // Reset between a search request and its result.
    @(negedge clk);
    search_enable = 1'b1;
    search_data   = 32'h4444_4444;
    search_mask   = '0;
    read_enable   = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    check("rst_mid_search_valid", 32'(search_valid), 32'd0);
    check("rst_mid_search_multi", 32'(search_multi), 32'd0);
    check("rst_mid_read_valid", 32'(read_valid), 32'd0);
    check("rst_mid_occupancy", 32'(occupancy), 32'd0);
    check("rst_mid_full", 32'(full), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    idle_step();
    step(1, 4, 0, 0, '0, 0, 0, 1, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
